// File: rtl/lsf_hough_pkg.sv
// Shared types and defaults for the LSF Hough path: accumulator state and peak report payload.
package lsf_hough_pkg;

  localparam int unsigned RBINS_DEF  = 128;
  localparam int unsigned W_RBIN_DEF = 7;
  localparam int unsigned W_CNT_DEF  = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } hough_acc_state_t;

  // Peak report as seen by the theta-slice peak merger.
  typedef struct packed {
    logic                  found;
    logic [W_RBIN_DEF-1:0] bin;
    logic [W_CNT_DEF-1:0]  count;
  } hough_peak_t;

endpackage

// File: rtl/hough_vote_counter_bank.sv
// RBINS x W_CNT saturating vote counters with a synchronous clear.
// The read port returns the stored count plus one, saturated.
module hough_vote_counter_bank
  import lsf_hough_pkg::*;
#(
  parameter int unsigned RBINS = RBINS_DEF,
  parameter int unsigned W_IDX = W_RBIN_DEF,
  parameter int unsigned W_CNT = W_CNT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [W_IDX-1:0] idx_i,
  output logic [W_CNT-1:0] nxt_cnt_c_o
);

  localparam logic [W_CNT-1:0] CNT_MAX = '1;

  logic [W_CNT-1:0] cnt_q [RBINS];
  logic [W_CNT-1:0] cnt_d [RBINS];
  logic             idx_ok;
  logic [W_CNT-1:0] rd_cnt;

  // A clear in the same cycle as a vote makes the vote see an empty bin.
  always_comb begin
    idx_ok      = ({1'b0, idx_i} < (W_IDX+1)'(RBINS));
    rd_cnt      = '0;
    if (idx_ok && !clear_i) begin
      rd_cnt = cnt_q[idx_i];
    end
    nxt_cnt_c_o = (rd_cnt == CNT_MAX) ? rd_cnt : rd_cnt + W_CNT'(1);
  end

  always_comb begin
    for (int i = 0; i < int'(RBINS); i++) begin
      cnt_d[i] = clear_i ? '0 : cnt_q[i];
    end
    if (inc_i && idx_ok) begin
      cnt_d[idx_i] = nxt_cnt_c_o;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RBINS); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(RBINS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: rtl/hough_rbin_accumulator.sv
// Per-event r-bin vote histogram for one theta slice with running-peak tracking;
// reports the peak bin/count once per event, one cycle after end_evt.
module hough_rbin_accumulator
  import lsf_hough_pkg::*;
#(
  parameter int unsigned W_bin_number_a = W_RBIN_DEF,
  parameter int unsigned RBINS          = RBINS_DEF,
  parameter int unsigned W_CNT          = W_CNT_DEF,
  parameter int unsigned MIN_HITS       = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic                      r_bin_vld_i,
  input  logic [W_bin_number_a-1:0] r_bin_i,
  input  logic                      end_evt_i,
  output logic                      peak_vld_o,
  output logic                      peak_found_o,
  output logic [W_bin_number_a-1:0] peak_bin_o,
  output logic [W_CNT-1:0]          peak_count_o,
  output logic                      busy_o,
  output logic                      stray_vote_o,
  output logic                      evt_abort_o
);

  localparam int unsigned W_BIN = W_bin_number_a;

  hough_acc_state_t state_q, state_d;
  logic [W_CNT-1:0] max_cnt_q, max_cnt_d;
  logic [W_BIN-1:0] max_bin_q, max_bin_d;
  logic             peak_vld_d, peak_found_d, busy_d, stray_d, abort_d;
  logic [W_BIN-1:0] peak_bin_d;
  logic [W_CNT-1:0] peak_count_d;

  logic             in_accum;
  logic             vote_ok;
  logic             report;
  logic [W_CNT-1:0] nxt_cnt;
  logic [W_CNT-1:0] base_cnt;
  logic [W_BIN-1:0] base_bin;

  hough_vote_counter_bank #(
    .RBINS (RBINS),
    .W_IDX (W_BIN),
    .W_CNT (W_CNT)
  ) u_bank (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (start_i),
    .inc_i       (vote_ok),
    .idx_i       (r_bin_i),
    .nxt_cnt_c_o (nxt_cnt)
  );

  always_comb begin
    state_d      = state_q;
    max_cnt_d    = max_cnt_q;
    max_bin_d    = max_bin_q;
    peak_vld_d   = 1'b0;
    peak_found_d = 1'b0;
    peak_bin_d   = '0;
    peak_count_d = '0;

    in_accum = (state_q == ACCUM);
    vote_ok  = r_bin_vld_i && ({1'b0, r_bin_i} < (W_BIN+1)'(RBINS)) && (in_accum || start_i);
    report   = in_accum && end_evt_i && !start_i;

    // Peak tracking starts from zero when a new event opens in this cycle.
    base_cnt = start_i ? '0 : max_cnt_q;
    base_bin = start_i ? '0 : max_bin_q;
    max_cnt_d = base_cnt;
    max_bin_d = base_bin;
    if (vote_ok && (nxt_cnt > base_cnt)) begin
      max_cnt_d = nxt_cnt;
      max_bin_d = r_bin_i;
    end

    case (state_q)
      IDLE:    if (start_i) state_d = ACCUM;
      ACCUM:   if (start_i) state_d = ACCUM;
               else if (end_evt_i) state_d = REPORT;
      REPORT:  state_d = start_i ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase

    if (report) begin
      peak_vld_d   = 1'b1;
      peak_found_d = (max_cnt_d >= W_CNT'(MIN_HITS));
      peak_bin_d   = max_bin_d;
      peak_count_d = max_cnt_d;
    end

    busy_d  = (state_d == ACCUM);
    stray_d = r_bin_vld_i && !vote_ok;
    abort_d = start_i && in_accum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      max_cnt_q    <= '0;
      max_bin_q    <= '0;
      peak_vld_o   <= 1'b0;
      peak_found_o <= 1'b0;
      peak_bin_o   <= '0;
      peak_count_o <= '0;
      busy_o       <= 1'b0;
      stray_vote_o <= 1'b0;
      evt_abort_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      max_cnt_q    <= max_cnt_d;
      max_bin_q    <= max_bin_d;
      peak_vld_o   <= peak_vld_d;
      peak_found_o <= peak_found_d;
      peak_bin_o   <= peak_bin_d;
      peak_count_o <= peak_count_d;
      busy_o       <= busy_d;
      stray_vote_o <= stray_d;
      evt_abort_o  <= abort_d;
    end
  end

endmodule

// File: tb/tb_hough_rbin_accumulator.sv
// Self-checking bench: histogram/peak reference model checked every cycle, directed cases
// with literal expectations, then a randomized run.
module tb_hough_rbin_accumulator;

  localparam int unsigned W    = 7;
  localparam int unsigned RB   = 128;
  localparam int unsigned WC   = 5;
  localparam int unsigned MH   = 3;
  localparam int          CMAX = 31;

  logic          clk = 1'b0;
  logic          rst_n, start_i, r_bin_vld_i, end_evt_i;
  logic [W-1:0]  r_bin_i;
  logic          peak_vld_o, peak_found_o, busy_o, stray_vote_o, evt_abort_o;
  logic [W-1:0]  peak_bin_o;
  logic [WC-1:0] peak_count_o;

  always #5 clk = ~clk;

  hough_rbin_accumulator #(
    .W_bin_number_a (W),
    .RBINS          (RB),
    .W_CNT          (WC),
    .MIN_HITS       (MH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .r_bin_vld_i  (r_bin_vld_i),
    .r_bin_i      (r_bin_i),
    .end_evt_i    (end_evt_i),
    .peak_vld_o   (peak_vld_o),
    .peak_found_o (peak_found_o),
    .peak_bin_o   (peak_bin_o),
    .peak_count_o (peak_count_o),
    .busy_o       (busy_o),
    .stray_vote_o (stray_vote_o),
    .evt_abort_o  (evt_abort_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: histogram plus the vote number at which each bin reached its current count.
  int  hist  [RB];
  int  reach [RB];
  int  vote_no;
  int  m_state;  // 0 idle, 1 collecting votes, 2 reporting
  bit  chk_en = 1'b0;
  int  e_vld, e_found, e_bin, e_cnt, e_busy, e_stray, e_abort;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < int'(RB); i++) begin
      hist[i]  = 0;
      reach[i] = 0;
    end
    vote_no = 0;
  endfunction

  // Predict the outputs visible after the coming clock edge.
  function automatic void model_step(input bit rn, input bit st, input bit v, input int b, input bit en);
    bit collecting, accept, rep;
    int best, best_bin, best_t;
    e_vld = 0; e_found = 0; e_bin = 0; e_cnt = 0; e_busy = 0; e_stray = 0; e_abort = 0;
    if (!rn) begin
      model_clear();
      m_state = 0;
      return;
    end
    collecting = (m_state == 1);
    e_abort = int'(st && collecting);
    if (st) model_clear();
    accept  = v && (b < int'(RB)) && (collecting || st);
    e_stray = int'(v && !accept);
    if (accept) begin
      vote_no++;
      if (hist[b] < CMAX) begin
        hist[b]++;
        reach[b] = vote_no;
      end
    end
    rep = collecting && en && !st;
    if (rep) begin
      best = 0; best_bin = 0; best_t = 0;
      for (int i = 0; i < int'(RB); i++) begin
        if (hist[i] > best || (hist[i] == best && best > 0 && reach[i] < best_t)) begin
          best = hist[i]; best_bin = i; best_t = reach[i];
        end
      end
      e_vld = 1; e_bin = best_bin; e_cnt = best; e_found = int'(best >= int'(MH));
    end
    if (st)              m_state = 1;
    else if (rep)        m_state = 2;
    else if (m_state==2) m_state = 0;
    e_busy = int'(m_state == 1);
  endfunction

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("peak_vld",   int'(peak_vld_o),   e_vld);
      check("peak_found", int'(peak_found_o), e_found);
      check("peak_bin",   int'(peak_bin_o),   e_bin);
      check("peak_count", int'(peak_count_o), e_cnt);
      check("busy",       int'(busy_o),       e_busy);
      check("stray_vote", int'(stray_vote_o), e_stray);
      check("evt_abort",  int'(evt_abort_o),  e_abort);
    end
  end

  task automatic step(input bit rn, input bit st, input bit v, input int b, input bit en);
    @(negedge clk);
    rst_n       = rn;
    start_i     = st;
    r_bin_vld_i = v;
    r_bin_i     = W'(b);
    end_evt_i   = en;
    model_step(rn, st, v, b, en);
    chk_en = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic vote(input int b);
    step(1'b1, 1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic lit_peak(input string name, input int vld, input int bin, input int cnt, input int found);
    check({name, ".vld"},   int'(peak_vld_o),   vld);
    check({name, ".bin"},   int'(peak_bin_o),   bin);
    check({name, ".count"}, int'(peak_count_o), cnt);
    check({name, ".found"}, int'(peak_found_o), found);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; r_bin_vld_i = 1'b0; r_bin_i = '0; end_evt_i = 1'b0;
    m_state = 0;
    model_clear();
    step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    check("reset.busy", int'(busy_o), 0);
    check("reset.peak_vld", int'(peak_vld_o), 0);
    idle(2);

    // 1: majority bin
    step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    check("t1.busy", int'(busy_o), 1);
    vote(5); vote(5); vote(9); vote(5);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1);
    lit_peak("t1", 1, 5, 3, 1);
    idle(1);
    check("t1.after", int'(peak_vld_o), 0);

    // 2: tie goes to the bin that reached the count first
    step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    vote(10); vote(20); vote(20); vote(10);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1);
    lit_peak("t2", 1, 20, 2, 0);
    idle(1);

    // 3: saturation
    step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 40; i++) vote(127);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1);
    lit_peak("t3", 1, 127, 31, 1);
    idle(1);

    // 4: stray votes in IDLE and in REPORT
    vote(50);
    check("t4.stray_idle", int'(stray_vote_o), 1);
    step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    vote(9);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1);
    vote(50);
    check("t4.stray_report", int'(stray_vote_o), 1);
    step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    vote(9);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1);
    lit_peak("t4", 1, 9, 1, 0);
    idle(1);

    // 5: start with vote, then abort with a new start+vote
    step(1'b1, 1'b1, 1'b1, 3, 1'b0);
    step(1'b1, 1'b1, 1'b1, 7, 1'b0);
    check("t5.abort", int'(evt_abort_o), 1);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1);
    lit_peak("t5", 1, 7, 1, 0);
    idle(1);

    // 6: reset mid-event
    step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    vote(4); vote(4);
    step(1'b0, 1'b0, 1'b1, 4, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1);
    lit_peak("t6", 0, 0, 0, 0);
    check("t6.busy", int'(busy_o), 0);

    // zero-vote event and start+end collision
    step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1);
    lit_peak("zero", 1, 0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 2, 1'b1);
    check("collide.vld", int'(peak_vld_o), 0);
    check("collide.abort", int'(evt_abort_o), 1);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1);
    lit_peak("collide", 1, 2, 1, 0);
    idle(2);

    // randomized traffic; bins biased to a small set to force ties and saturation
    for (int i = 0; i < 4000; i++) begin
      bit rn, st, v, en;
      int b;
      rn = ($urandom_range(0, 199) != 0);
      st = ($urandom_range(0, 39) == 0);
      en = ($urandom_range(0, 24) == 0);
      v  = ($urandom_range(0, 9) < 7);
      b  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, RB-1));
      step(rn, st, v, b, en);
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
